// File: rtl/shift_decoder.sv
// shift_decoder: recovers the command of the 4-bit shift/rotate unit from an
// original/transformed word pair. It tries one candidate (direction, amount)
// per clock in a fixed order, and the first candidate that reproduces the
// transformed word is reported.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   start_i        request pulse, sampled only while idle
//   select_i       0 = shift (zero fill), 1 = rotate; captured on accepted start
//   orig_i         original word; captured on accepted start
//   shifted_i      transformed word; captured on accepted start
//   busy_o         high while searching
//   done_o         one-cycle completion pulse
//   found_o        a matching candidate was found (held until the next result)
//   direction_o    0 = right, 1 = left (held like found_o)
//   shift_value_o  recovered amount 0..3 (held like found_o)
module shift_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic       select_i,
    input  logic [3:0] orig_i,
    input  logic [3:0] shifted_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       found_o,
    output logic       direction_o,
    output logic [1:0] shift_value_o
);

    typedef enum logic [1:0] {StIdle, StSearch, StDone} state_e;

    localparam logic [2:0] LastCand = 3'd6;

    state_e     state_q, state_d;
    logic       sel_q, sel_d;
    logic [3:0] orig_q, orig_d;
    logic [3:0] shifted_q, shifted_d;
    logic [2:0] cand_q, cand_d;
    logic       found_q, found_d;
    logic       dir_q, dir_d;
    logic [1:0] amt_q, amt_d;

    logic       cand_dir;
    logic [1:0] cand_amt;
    logic [3:0] cand_word;
    logic       cand_match;

    // Right by k: out[i] = in[i+k]; positions past the MSB get zero or wrap.
    function automatic logic [3:0] right_xform(input logic [3:0] din, input logic [1:0] k,
                                               input logic rot);
        logic [3:0] dout;
        logic [2:0] idx;
        dout = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            idx = 3'(i) + {1'b0, k};
            if (idx > 3'd3) begin
                dout[i] = rot ? din[idx[1:0]] : 1'b0;
            end else begin
                dout[i] = din[idx[1:0]];
            end
        end
        return dout;
    endfunction

    function automatic logic [3:0] bit_rev(input logic [3:0] din);
        return {din[0], din[1], din[2], din[3]};
    endfunction

    // Candidates 0..3 are right 0..3, candidates 4..6 are left 1..3.
    always_comb begin
        cand_dir = cand_q[2];
        cand_amt = cand_q[2] ? (cand_q[1:0] + 2'd1) : cand_q[1:0];
        if (cand_dir) begin
            // Left is the mirror image of right, so zero fill enters at the LSBs.
            cand_word = bit_rev(right_xform(bit_rev(orig_q), cand_amt, sel_q));
        end else begin
            cand_word = right_xform(orig_q, cand_amt, sel_q);
        end
        cand_match = (cand_word == shifted_q);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            sel_q     <= 1'b0;
            orig_q    <= 4'b0000;
            shifted_q <= 4'b0000;
            cand_q    <= 3'd0;
            found_q   <= 1'b0;
            dir_q     <= 1'b0;
            amt_q     <= 2'd0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            orig_q    <= orig_d;
            shifted_q <= shifted_d;
            cand_q    <= cand_d;
            found_q   <= found_d;
            dir_q     <= dir_d;
            amt_q     <= amt_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        orig_d    = orig_q;
        shifted_d = shifted_q;
        cand_d    = cand_q;
        found_d   = found_q;
        dir_d     = dir_q;
        amt_d     = amt_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    sel_d     = select_i;
                    orig_d    = orig_i;
                    shifted_d = shifted_i;
                    cand_d    = 3'd0;
                    state_d   = StSearch;
                end
            end
            StSearch: begin
                if (cand_match) begin
                    found_d = 1'b1;
                    dir_d   = cand_dir;
                    amt_d   = cand_amt;
                    state_d = StDone;
                end else if (cand_q == LastCand) begin
                    found_d = 1'b0;
                    dir_d   = 1'b0;
                    amt_d   = 2'd0;
                    state_d = StDone;
                end else begin
                    cand_d = cand_q + 3'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs.
    always_comb begin
        busy_o        = (state_q == StSearch);
        done_o        = (state_q == StDone);
        found_o       = found_q;
        direction_o   = dir_q;
        shift_value_o = amt_q;
    end

endmodule

// File: tb/tb_shift_decoder.sv
// Testbench for shift_decoder: directed cases, protocol/reset scenarios and
// randomized operations checked against an arithmetic reference model.
module tb_shift_decoder;

    logic       clk;
    logic       rst_n;
    logic       start_i;
    logic       select_i;
    logic [3:0] orig_i;
    logic [3:0] shifted_i;
    logic       busy_o;
    logic       done_o;
    logic       found_o;
    logic       direction_o;
    logic [1:0] shift_value_o;

    int n_tests = 0;
    int n_fail  = 0;

    shift_decoder u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .select_i     (select_i),
        .orig_i       (orig_i),
        .shifted_i    (shifted_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .found_o      (found_o),
        .direction_o  (direction_o),
        .shift_value_o(shift_value_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Shifter behaviour written as plain integer arithmetic.
    function automatic int xform(input int sel, input int v, input int dir, input int k);
        if (dir == 0) begin
            return (sel != 0) ? (((v >> k) | (v << (4 - k))) & 15) : (v >> k);
        end
        return (sel != 0) ? (((v << k) | (v >> (4 - k))) & 15) : ((v << k) & 15);
    endfunction

    // First match in order right 0..3, left 1..3; latency is position + 1.
    function automatic void model(input int sel, input int o, input int s, output int f,
                                  output int d, output int a, output int lat);
        f = 0; d = 0; a = 0; lat = 7;
        for (int j = 0; j < 7; j++) begin
            int dir;
            int k;
            dir = (j >= 4) ? 1 : 0;
            k   = (j >= 4) ? j - 3 : j;
            if (xform(sel, o, dir, k) == s) begin
                f = 1; d = dir; a = k; lat = j + 1;
                break;
            end
        end
    endfunction

    // Called at the first negedge after the accepting edge. Returns the latency
    // in clocks (-1 on timeout) and the number of busy cycles seen.
    task automatic wait_done(input bit scramble, output int lat, output int bc);
        lat = -1;
        bc  = 0;
        for (int n = 1; n <= 20; n++) begin
            if (busy_o) bc++;
            if (done_o) begin
                lat = n - 1;
                break;
            end
            if (scramble) begin
                select_i  = 1'($urandom_range(1));
                orig_i    = 4'($urandom_range(15));
                shifted_i = 4'($urandom_range(15));
            end
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input int sel, input int o, input int s,
                                input int lat, input int bc);
        int ef, ed, ea, el;
        model(sel, o, s, ef, ed, ea, el);
        check({tag, ".lat"}, lat, el);
        check({tag, ".busy"}, bc, el);
        check({tag, ".found"}, int'(found_o), ef);
        check({tag, ".dir"}, int'(direction_o), ed);
        check({tag, ".amt"}, int'(shift_value_o), ea);
        // Next cycle: pulse over, back to idle, results held.
        @(negedge clk);
        check({tag, ".done1"}, int'(done_o), 0);
        check({tag, ".idle"}, int'(busy_o), 0);
        check({tag, ".hold"}, {int'(found_o), int'(direction_o), int'(shift_value_o)},
              {ef, ed, ea});
    endtask

    task automatic start_op(input int sel, input int o, input int s);
        @(negedge clk);
        select_i  = 1'(sel);
        orig_i    = 4'(o);
        shifted_i = 4'(s);
        start_i   = 1'b1;
        @(negedge clk);
        start_i   = 1'b0;
    endtask

    task automatic run_op(input string tag, input int sel, input int o, input int s);
        int lat, bc;
        start_op(sel, o, s);
        wait_done(1'b0, lat, bc);
        check_result(tag, sel, o, s, lat, bc);
    endtask

    initial begin
        int lat, bc;
        rst_n     = 1'b0;
        start_i   = 1'b0;
        select_i  = 1'b0;
        orig_i    = 4'd0;
        shifted_i = 4'd0;
        repeat (3) @(negedge clk);
        check("rst.busy", int'(busy_o), 0);
        check("rst.done", int'(done_o), 0);
        check("rst.found", int'(found_o), 0);
        check("rst.dir", int'(direction_o), 0);
        check("rst.amt", int'(shift_value_o), 0);
        rst_n = 1'b1;

        // Directed cases.
        run_op("rotr1", 1, 4'b1011, 4'b1101);
        run_op("shl2", 0, 4'b0011, 4'b1100);
        run_op("nomatch", 0, 4'b0001, 4'b0101);
        run_op("zero", 0, 4'b0000, 4'b0000);
        run_op("rotl1", 1, 4'b0001, 4'b0010);
        check("rotl1.amt3", int'(shift_value_o), 3);

        // Start held high, inputs scrambled after acceptance; start in the done
        // cycle ignored, the following idle cycle's start accepted.
        @(negedge clk);
        select_i  = 1'b0;
        orig_i    = 4'b0110;
        shifted_i = 4'b1100;
        start_i   = 1'b1;
        @(negedge clk);
        wait_done(1'b1, lat, bc);
        check_result("hold", 0, 4'b0110, 4'b1100, lat, bc);
        select_i  = 1'b1;
        orig_i    = 4'b1000;
        shifted_i = 4'b0001;
        @(negedge clk);
        check("b2b.accept", int'(busy_o), 1);
        start_i = 1'b0;
        wait_done(1'b0, lat, bc);
        check_result("b2b", 1, 4'b1000, 4'b0001, lat, bc);

        // Reset while evaluating candidate 3 of a no-match search.
        run_op("prev", 0, 4'b0100, 4'b1000);
        start_op(0, 4'b0001, 4'b0101);
        repeat (3) @(negedge clk);
        check("mid.busy_pre", int'(busy_o), 1);
        rst_n = 1'b0;
        #1;
        check("mid.busy", int'(busy_o), 0);
        check("mid.done", int'(done_o), 0);
        check("mid.res", {int'(found_o), int'(direction_o), int'(shift_value_o)}, 0);
        repeat (2) @(negedge clk);
        check("mid.nodone", int'(done_o), 0);
        rst_n = 1'b1;
        run_op("after_rst", 1, 4'b0110, 4'b0011);

        // Randomized operations, half built from a real transform of orig.
        for (int i = 0; i < 60; i++) begin
            int sel, o, s;
            sel = int'($urandom_range(1));
            o   = int'($urandom_range(15));
            if ($urandom_range(1) == 1) begin
                int dir;
                dir = int'($urandom_range(1));
                s   = xform(sel, o, dir, int'($urandom_range(3)));
            end else begin
                s = int'($urandom_range(15));
            end
            run_op("rand", sel, o, s);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
